// File: rtl/bcd_pkg.sv
// bcd_pkg
// Shared definitions for the BCD-to-binary converter family.
//   IDLE / CONV : FSM state encoding
//   DIG_MAX     : largest legal BCD digit value
//   clog2()     : ceiling log2, used to size the digit counter
//   bin_width() : minimal result width able to hold 10^ndig - 1
package bcd_pkg;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] CONV = 1'b1;

    localparam logic [3:0] DIG_MAX = 4'd9;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

    // Smallest w with 2^w >= 10^ndig, i.e. 2^w > 10^ndig - 1.
    function automatic int bin_width(input int ndig);
        logic [127:0] lim;
        int           r;
        lim = 128'd1;
        for (int i = 0; i < ndig; i++) lim = lim * 128'd10;
        r = 0;
        for (int i = 0; i < 128; i++) begin
            if ((128'd1 << i) < lim) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_mac10.sv
// bcd_mac10
// Combinational Horner step: sum = acc*10 + d, with an invalid-digit flag.
// The multiply by ten is built from two shifts and an add.
//   acc : running binary accumulator
//   d   : next BCD digit (raw nibble, A-F still accumulated)
//   sum : acc*10 + d, modulo 2^BW
//   bad : d is not a legal BCD digit
module bcd_mac10
    import bcd_pkg::*;
#(
    parameter int BW = 27
) (
    input  logic [BW-1:0] acc,
    input  logic [3:0]    d,
    output logic [BW-1:0] sum,
    output logic          bad
);

    assign sum = (acc << 3) + (acc << 1) + BW'(d);
    assign bad = (d > DIG_MAX);

endmodule

// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq
// Sequential MSD-first BCD-to-binary converter, one digit per clock.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   st   : start request, only honoured while idle
//   DEC  : packed BCD operand, digit 0 (LSD) in DEC[3:0]
//   BIN  : converted result, held until the next completion
//   ok   : one-cycle completion strobe, aligned with the BIN update
//   busy : high while a conversion is running
//   err  : last completed operand contained a digit above 9
module bcd_to_bin_seq
    import bcd_pkg::*;
#(
    parameter int NDIG = 8,
    parameter int BW   = 27
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            st,
    input  logic [4*NDIG-1:0] DEC,
    output logic [BW-1:0]   BIN,
    output logic            ok,
    output logic            busy,
    output logic            err
);

    localparam int CW = (clog2(NDIG) < 1) ? 1 : clog2(NDIG);

    generate
        if (NDIG < 1) begin : g_ndig_check
            $error("bcd_to_bin_seq: NDIG must be at least 1");
        end
        if (BW < bin_width(NDIG)) begin : g_bw_check
            $error("bcd_to_bin_seq: BW too narrow for 10^NDIG - 1");
        end
    endgenerate

    logic [0:0]        state;
    logic [4*NDIG-1:0] sr;
    logic [BW-1:0]     acc;
    logic [CW-1:0]     cnt;
    logic              err_acc;

    logic [3:0]        digit;
    logic [BW-1:0]     acc_next;
    logic              digit_bad;

    // The operand is shifted left, so the most significant digit is always on top.
    assign digit = sr[4*NDIG-1 -: 4];
    assign busy  = (state == CONV);

    bcd_mac10 #(.BW(BW)) u_mac (
        .acc (acc),
        .d   (digit),
        .sum (acc_next),
        .bad (digit_bad)
    );

    // BIN and err are touched only on the final CONV edge, so a new start
    // leaves the previous result visible until its replacement is ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            sr      <= '0;
            acc     <= '0;
            cnt     <= '0;
            err_acc <= 1'b0;
            BIN     <= '0;
            err     <= 1'b0;
            ok      <= 1'b0;
        end else begin
            ok <= 1'b0;
            if (state == IDLE) begin
                if (st) begin
                    sr      <= DEC;
                    acc     <= '0;
                    err_acc <= 1'b0;
                    cnt     <= '0;
                    state   <= CONV;
                end
            end else begin
                acc     <= acc_next;
                sr      <= sr << 4;
                err_acc <= err_acc | digit_bad;
                cnt     <= cnt + 1'b1;
                if (cnt == CW'(NDIG - 1)) begin
                    BIN   <= acc_next;
                    err   <= err_acc | digit_bad;
                    ok    <= 1'b1;
                    state <= IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb_bcd_to_bin_seq
// Directed bench for bcd_to_bin_seq: an 8-digit/27-bit instance and a
// 1-digit/4-bit instance sharing clock and reset.
module tb_bcd_to_bin_seq;

    logic        clk;
    logic        rst;
    logic        st;
    logic [31:0] dec;
    logic [26:0] bin;
    logic        ok;
    logic        busy;
    logic        err;

    logic        st1;
    logic [3:0]  dec1;
    logic [3:0]  bin1;
    logic        ok1;
    logic        busy1;
    logic        err1;

    int checks;
    int errors;

    bcd_to_bin_seq #(.NDIG(8), .BW(27)) dut (
        .clk  (clk),
        .rst  (rst),
        .st   (st),
        .DEC  (dec),
        .BIN  (bin),
        .ok   (ok),
        .busy (busy),
        .err  (err)
    );

    bcd_to_bin_seq #(.NDIG(1), .BW(4)) dut1 (
        .clk  (clk),
        .rst  (rst),
        .st   (st1),
        .DEC  (dec1),
        .BIN  (bin1),
        .ok   (ok1),
        .busy (busy1),
        .err  (err1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] d);
        dec = d;
        st  = 1'b1;
        tick();
        st  = 1'b0;
    endtask

    // Counts edges after acceptance until ok, bounded.
    task automatic waitOk(output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        while (!ok && lat < 40) begin
            busy_cnt += int'(busy);
            tick();
            lat++;
        end
    endtask

    task automatic runConv(input string tag, input logic [31:0] d,
                           input logic [31:0] exp_bin, input logic exp_err);
        int lat;
        int bc;
        applyStimulus(d);
        waitOk(lat, bc);
        checkOutput({tag, "_latency"}, 32'(lat), 32'd8);
        checkOutput({tag, "_busy_cycles"}, 32'(bc), 32'd8);
        checkOutput({tag, "_bin"}, 32'(bin), exp_bin);
        checkOutput({tag, "_err"}, 32'(err), 32'(exp_err));
        checkOutput({tag, "_busy_at_ok"}, 32'(busy), 32'd0);
        tick();
        checkOutput({tag, "_ok_falls"}, 32'(ok), 32'd0);
    endtask

    initial begin
        int lat;
        int bc;
        int ok_cnt;
        int first_ok;
        logic [31:0] bin_at_ok;

        checks = 0;
        errors = 0;
        rst  = 1'b1;
        st   = 1'b0;
        dec  = '0;
        st1  = 1'b0;
        dec1 = '0;

        tick();
        tick();
        checkOutput("reset_bin", 32'(bin), 32'd0);
        checkOutput("reset_ok", 32'(ok), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_err", 32'(err), 32'd0);
        checkOutput("reset_bin1", 32'(bin1), 32'd0);
        rst = 1'b0;
        tick();

        runConv("c12345678", 32'h12345678, 32'h0BC614E, 1'b0);
        runConv("c99999999", 32'h99999999, 32'h5F5E0FF, 1'b0);
        runConv("c0", 32'h00000000, 32'd0, 1'b0);
        runConv("cA1", 32'h000000A1, 32'd101, 1'b1);

        // Previous result must stay visible while the next conversion runs.
        applyStimulus(32'h00000042);
        checkOutput("hold_bin", 32'(bin), 32'd101);
        checkOutput("hold_err", 32'(err), 32'd1);
        checkOutput("hold_busy", 32'(busy), 32'd1);
        waitOk(lat, bc);
        checkOutput("c42_latency", 32'(lat), 32'd8);
        checkOutput("c42_bin", 32'(bin), 32'd42);
        checkOutput("c42_err", 32'(err), 32'd0);
        tick();

        // Operand change after acceptance and a start while busy are ignored.
        dec = 32'h00000007;
        st  = 1'b1;
        tick();
        dec = 32'h55555555;
        st  = 1'b0;
        tick();
        tick();
        st = 1'b1;
        tick();
        st = 1'b0;
        ok_cnt    = 0;
        first_ok  = -1;
        bin_at_ok = '0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (ok) begin
                ok_cnt++;
                if (first_ok < 0) begin
                    first_ok  = i;
                    bin_at_ok = 32'(bin);
                end
            end
        end
        checkOutput("ignore_ok_count", 32'(ok_cnt), 32'd1);
        checkOutput("ignore_ok_edge", 32'(first_ok), 32'd5);
        checkOutput("ignore_bin", bin_at_ok, 32'd7);
        checkOutput("ignore_busy_after", 32'(busy), 32'd0);

        // Reset during the fourth clock of a conversion.
        applyStimulus(32'h12345678);
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        checkOutput("abort_bin", 32'(bin), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_ok", 32'(ok), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        ok_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            ok_cnt += int'(ok);
        end
        checkOutput("abort_no_ok", 32'(ok_cnt), 32'd0);
        checkOutput("abort_bin_held", 32'(bin), 32'd0);
        runConv("after_abort", 32'h12345678, 32'h0BC614E, 1'b0);

        // Back-to-back with start held high.
        dec = 32'h00000123;
        st  = 1'b1;
        tick();
        waitOk(lat, bc);
        checkOutput("b2b_first_latency", 32'(lat), 32'd8);
        checkOutput("b2b_first_bin", 32'(bin), 32'd123);
        for (int k = 0; k < 2; k++) begin
            tick();
            lat = 1;
            while (!ok && lat < 40) begin
                tick();
                lat++;
            end
            checkOutput("b2b_interval", 32'(lat), 32'd9);
            checkOutput("b2b_bin", 32'(bin), 32'd123);
            checkOutput("b2b_busy_at_ok", 32'(busy), 32'd0);
        end
        st = 1'b0;
        tick();
        checkOutput("b2b_stop_busy", 32'(busy), 32'd0);

        // Single-digit instance: ok every two clocks with start held.
        dec1 = 4'h9;
        st1  = 1'b1;
        tick();
        checkOutput("n1_busy", 32'(busy1), 32'd1);
        checkOutput("n1_ok_early", 32'(ok1), 32'd0);
        tick();
        checkOutput("n1_ok", 32'(ok1), 32'd1);
        checkOutput("n1_bin", 32'(bin1), 32'd9);
        for (int k = 0; k < 2; k++) begin
            tick();
            checkOutput("n1_gap_ok", 32'(ok1), 32'd0);
            tick();
            checkOutput("n1_repeat_ok", 32'(ok1), 32'd1);
            checkOutput("n1_repeat_bin", 32'(bin1), 32'd9);
        end
        st1 = 1'b0;
        tick();
        dec1 = 4'hA;
        st1  = 1'b1;
        tick();
        st1 = 1'b0;
        tick();
        checkOutput("n1_bad_ok", 32'(ok1), 32'd1);
        checkOutput("n1_bad_bin", 32'(bin1), 32'd10);
        checkOutput("n1_bad_err", 32'(err1), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_to_bin_seq.md
# bcd_to_bin_seq

Sequential, parametrised BCD-to-binary converter. It is the generalised successor of the team's fixed 8-digit / 27-bit decimal-to-binary unit. Conversion is MSD-first Horner (acc·10 + digit), one digit per clock. It adds an input capture register, busy/ok handshake, invalid-digit detection and asynchronous reset. It sits between decimal-entry/display logic and the binary datapath.

## Interface
- NDIG, 8, number of BCD digits in one conversion (≥1)
- BW, 27, result width; must satisfy 2^BW > 10^NDIG − 1 (elaboration-time check fails otherwise)

- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous and active-high
- st  in  1  start request, sampled only while idle
- DEC  in  4·NDIG  packed BCD operand, digit 0 (LSD) in DEC[3:0]
- BIN  out  BW  converted result, held until the next completion
- ok  out  1  one-cycle completion strobe, aligned with the BIN update
- busy  out  1  high while a conversion is in progress
- err  out  1  at least one digit >9 in the last completed operand; updated with ok

## Operation
- States:
  - IDLE: on st=1, capture DEC into shift register sr, clear acc, clear err_acc, cnt=0, go to CONV.
  - CONV: every edge does all of the following:
    - d = sr top nibble;
    - acc ← acc·10 + d (mod 2^BW);
    - sr ← sr<<4;
    - err_acc |= (d>9);
    - cnt++.
  - CONV exit: on the edge with cnt=NDIG−1, perform that edge's update, then BIN ← final acc, err ← final err_acc, ok ← 1, go to IDLE.
- ·10 is implemented as (acc<<3)+(acc<<1). No multiplier.
- Invalid digit (A–F): its raw value is still accumulated. BIN is computed but flagged with err=1.
- DEC is sampled only at acceptance. Later changes have no effect on the running conversion.
- st while busy=1 is ignored. It is not queued.
- BIN and err are not cleared on st. They change only at completion.
- busy=1 exactly in CONV.

## Timing
- Reset (async assert, any state): state=IDLE; BIN=0, ok=0, busy=0, err=0; acc, sr and cnt cleared.
- Reset mid-conversion: the conversion is aborted. No ok is produced and BIN stays 0.
- st sampled high at edge E0 (state IDLE):
  - busy rises after E0.
  - Digits are consumed on edges E1…E_NDIG.
  - BIN, err and ok update after E_NDIG.
  - busy falls after E_NDIG.
  - ok falls after E_NDIG+1.
- Latency is NDIG clocks from the st edge to ok. Throughput is one result per NDIG+1 clocks.
- Back-to-back: st high during the ok cycle is accepted, because the state is IDLE. ok and the new busy then coexist for 0 cycles: ok is high in the cycle before busy.
- NDIG=1: a single CONV edge. ok appears 1 clock after st.

## Structure
- Shared package bcd_pkg holds:
  - state encoding (IDLE, CONV);
  - constant DIG_MAX=9;
  - function bin_width(ndig), returning the minimal BW, used for the parameter check;
  - clog2 helper for the cnt width.
- Sub-module bcd_mac10 (combinational): inputs acc[BW], d[4]; outputs acc·10+d and bad=(d>9). It is reused by future multi-digit-per-clock variants.
- Top bcd_to_bin_seq: FSM, sr, cnt, acc, output registers.

## Test plan
- NDIG=8, BW=27: DEC=32'h12345678, st pulse → after 8 clocks ok=1 for 1 clock, BIN=12345678 (0x0BC614E), err=0, busy high for exactly 8 clocks.
- DEC=32'h99999999 → BIN=99999999 (0x5F5E0FF), err=0. Then DEC=0 → BIN=0, err=0.
- DEC=32'h000000A1 → BIN=101, err=1. The next conversion of DEC=32'h00000042 gives BIN=42 with err=0.
- Sequence:
  - st=1 with DEC=32'h00000007;
  - DEC changed to 32'h55555555 on the next clock;
  - st pulsed again at clock 3 (ignored);
  - expected result: BIN=7, a single ok.
- Assert rst at clock 4 of a conversion → BIN=0, busy=0, ok never pulses. A fresh st after release gives the correct result.
- Back-to-back: st held high continuously with DEC=32'h00000123 → ok every 9 clocks, BIN=123 each time. Repeat with NDIG=1, BW=4 and DEC=4'h9 → BIN=9, ok every 2 clocks.
